// File: rtl/hit_merge_pkg.sv
// Shared types, default geometry and lane ids for the two-lane hit merger.
package hit_merge_pkg;

   // Default hit geometry; the top-level parameters default to these.
   localparam int unsigned HM_SIGFIG = 24;
   localparam int unsigned HM_AXIS   = 3;
   localparam int unsigned HM_COLORS = 3;
   localparam int unsigned HM_DEPTH  = 8;
   localparam int unsigned HM_SKID   = 5;

   // Lane ids as seen by the round-robin pointer.
   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   // One hit: signed position followed by unsigned color, position in the MSBs.
   typedef struct packed {
      logic signed [HM_AXIS-1:0][HM_SIGFIG-1:0] pos;
      logic        [HM_COLORS-1:0][HM_SIGFIG-1:0] color;
   } hit_t;

   // True when fewer than skid free slots would remain with cnt entries occupied.
   function automatic logic halt_needed(input int unsigned depth,
                                        input int unsigned skid,
                                        input int unsigned cnt);
      return (depth - cnt) < skid;
   endfunction

endpackage

// File: rtl/hit_merge_fifo.sv
// Per-lane hit FIFO: extra-MSB pointers, combinational read of the head entry.
module hit_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 144
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // Status flags, accepted handshakes and next pointers.
   always_comb begin
      empty   = (wptr_q == rptr_q);
      full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      count   = wptr_q - rptr_q;
      pop_ok  = pop & ~empty;
      // A push into a full FIFO still lands when the head leaves this cycle.
      push_ok = push & (~full | pop_ok);
      wptr_d  = wptr_q + {{AW{1'b0}}, push_ok};
      rptr_d  = rptr_q + {{AW{1'b0}}, pop_ok};
      dout    = mem_q[rptr_q[AW-1:0]];
   end

   // Pointer registers; clearing them discards every buffered entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array, written at the tail slot on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/hit_merge.sv
// Two-lane hit merger: per-lane FIFOs, round-robin arbitration into one
// registered ready/valid stream, skid-aware halt, sticky overflow, hit counter.
module hit_merge
   import hit_merge_pkg::*;
#(
   parameter int unsigned SIGFIG = HM_SIGFIG,
   parameter int unsigned AXIS   = HM_AXIS,
   parameter int unsigned COLORS = HM_COLORS,
   parameter int unsigned DEPTH  = HM_DEPTH,
   parameter int unsigned SKID   = HM_SKID
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S,
   input  logic [COLORS-1:0][SIGFIG-1:0]      color_R18U,
   input  logic                               hit_valid_R18H,
   input  logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S_2,
   input  logic [COLORS-1:0][SIGFIG-1:0]      color_R18U_2,
   input  logic                               hit_valid_R18H_2,
   output logic                               halt_RnnnnL,
   output logic signed [AXIS-1:0][SIGFIG-1:0] hit_R19S,
   output logic [COLORS-1:0][SIGFIG-1:0]      color_R19U,
   output logic                               hit_valid_R19H,
   input  logic                               ready_R19H,
   output logic                               overflow_RnnnnH,
   output logic [31:0]                        hit_count_RnnnnU
);

   localparam int unsigned POS_W = SIGFIG * AXIS;
   localparam int unsigned COL_W = SIGFIG * COLORS;
   localparam int unsigned HIT_W = POS_W + COL_W;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic [HIT_W-1:0] din0, din1, dout0, dout1;
   logic             full0, full1, empty0, empty1;
   logic [AW:0]      cnt0, cnt1;
   logic             pop0, pop1;
   logic             acc0, acc1;
   logic             drop0, drop1;
   logic             load;
   logic [31:0]      nc0, nc1;

   logic [HIT_W-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             rr_q, rr_d;
   logic             halt_q, halt_d;
   logic             ovf_q, ovf_d;
   logic [31:0]      cnt_q, cnt_d;

   assign din0 = {hit_R18S, color_R18U};
   assign din1 = {hit_R18S_2, color_R18U_2};

   hit_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (HIT_W)
   ) u_fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (hit_valid_R18H),
      .pop   (pop0),
      .din   (din0),
      .dout  (dout0),
      .full  (full0),
      .empty (empty0),
      .count (cnt0)
   );

   hit_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (HIT_W)
   ) u_fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (hit_valid_R18H_2),
      .pop   (pop1),
      .din   (din1),
      .dout  (dout1),
      .full  (full1),
      .empty (empty1),
      .count (cnt1)
   );

   // Arbitration, output-register load, and the next halt/overflow/count state.
   always_comb begin
      load  = ~valid_q | ready_R19H;
      pop0  = load & ~empty0 & (empty1 | (rr_q == LANE0));
      pop1  = load & ~empty1 & (empty0 | (rr_q == LANE1));

      acc0  = hit_valid_R18H   & (~full0 | pop0);
      acc1  = hit_valid_R18H_2 & (~full1 | pop1);
      drop0 = hit_valid_R18H   & full0 & ~pop0;
      drop1 = hit_valid_R18H_2 & full1 & ~pop1;

      rr_d = rr_q;
      if (load && !empty0 && !empty1) begin
         rr_d = ~rr_q;
      end

      out_d   = out_q;
      valid_d = valid_q;
      if (load) begin
         valid_d = ~empty0 | ~empty1;
         if (pop1) begin
            out_d = dout1;
         end else if (pop0) begin
            out_d = dout0;
         end
      end

      nc0    = 32'(cnt0) + 32'(acc0) - 32'(pop0);
      nc1    = 32'(cnt1) + 32'(acc1) - 32'(pop1);
      halt_d = ~(halt_needed(DEPTH, SKID, nc0) | halt_needed(DEPTH, SKID, nc1));

      ovf_d = ovf_q | drop0 | drop1;
      cnt_d = cnt_q + {31'd0, valid_q & ready_R19H};
   end

   // Merged-stream and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         rr_q    <= LANE0;
         halt_q  <= 1'b1;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         rr_q    <= rr_d;
         halt_q  <= halt_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hit_R19S         = out_q[HIT_W-1:COL_W];
   assign color_R19U       = out_q[COL_W-1:0];
   assign hit_valid_R19H   = valid_q;
   assign halt_RnnnnL      = halt_q;
   assign overflow_RnnnnH  = ovf_q;
   assign hit_count_RnnnnU = cnt_q;

endmodule

// File: tb/tb_hit_merge.sv
// Scoreboard bench for hit_merge: directed stimulus pushes expected hits in
// delivery order; a negedge monitor pops and compares on every valid & ready.
`timescale 1ns/1ps
module tb_hit_merge;
   import hit_merge_pkg::*;

   localparam int unsigned SIGFIG = 24;
   localparam int unsigned AXIS   = 3;
   localparam int unsigned COLORS = 3;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned SKID   = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [AXIS-1:0][SIGFIG-1:0] hit_R18S, hit_R18S_2, hit_R19S;
   logic [COLORS-1:0][SIGFIG-1:0]      color_R18U, color_R18U_2, color_R19U;
   logic hit_valid_R18H, hit_valid_R18H_2, hit_valid_R19H, ready_R19H;
   logic halt_RnnnnL, overflow_RnnnnH;
   logic [31:0] hit_count_RnnnnU;

   hit_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   hit_merge #(
      .SIGFIG (SIGFIG),
      .AXIS   (AXIS),
      .COLORS (COLORS),
      .DEPTH  (DEPTH),
      .SKID   (SKID)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .hit_R18S         (hit_R18S),
      .color_R18U       (color_R18U),
      .hit_valid_R18H   (hit_valid_R18H),
      .hit_R18S_2       (hit_R18S_2),
      .color_R18U_2     (color_R18U_2),
      .hit_valid_R18H_2 (hit_valid_R18H_2),
      .halt_RnnnnL      (halt_RnnnnL),
      .hit_R19S         (hit_R19S),
      .color_R19U       (color_R19U),
      .hit_valid_R19H   (hit_valid_R19H),
      .ready_R19H       (ready_R19H),
      .overflow_RnnnnH  (overflow_RnnnnH),
      .hit_count_RnnnnU (hit_count_RnnnnU)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic hit_t mk(input int x, input int y, input int z,
                               input int r, input int g, input int b);
      hit_t h;
      h.pos[0]   = x[SIGFIG-1:0];
      h.pos[1]   = y[SIGFIG-1:0];
      h.pos[2]   = z[SIGFIG-1:0];
      h.color[0] = r[SIGFIG-1:0];
      h.color[1] = g[SIGFIG-1:0];
      h.color[2] = b[SIGFIG-1:0];
      return h;
   endfunction

   task automatic drive(input logic v0, input hit_t h0, input logic v1, input hit_t h1);
      hit_valid_R18H   = v0;
      hit_R18S         = h0.pos;
      color_R18U       = h0.color;
      hit_valid_R18H_2 = v1;
      hit_R18S_2       = h1.pos;
      color_R18U_2     = h1.color;
   endtask

   // Advance one clock; inputs change and registered outputs are checked at edge + 1.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      check(name, exp_q.size(), 0);
      step();
      step();
      check({name, "_idle"}, hit_valid_R19H, 1'b0);
   endtask

   // Monitor: score every delivered hit and verify stalled outputs hold.
   hit_t got;
   hit_t held;
   logic stall = 1'b0;
   always @(negedge clk) begin
      got = {hit_R19S, color_R19U};
      if (!rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("hold_valid", hit_valid_R19H, 1'b1);
            check("hold_payload", got, held);
         end
         if (hit_valid_R19H && ready_R19H) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_hit actual=%0h required=none", got);
            end else begin
               check("payload", got, exp_q.pop_front());
            end
         end
         stall = hit_valid_R19H && !ready_R19H;
         held  = got;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   hit_t z, h, x;
   hit_t a[4], b[4];

   initial begin
      z = '0;
      drive(1'b0, z, 1'b0, z);
      ready_R19H = 1'b1;
      #1 rst = 1'b0;
      #2;
      check("rst_valid", hit_valid_R19H, 1'b0);
      check("rst_halt", halt_RnnnnL, 1'b1);
      check("rst_ovf", overflow_RnnnnH, 1'b0);
      check("rst_count", hit_count_RnnnnU, 32'd0);
      check("rst_payload", {hit_R19S, color_R19U}, 144'd0);
      step();
      rst = 1'b1;
      step();

      // Single lane-0 hit: visible after the second edge, for exactly one cycle.
      h = mk(1, 2, 3, 255, 0, 0);
      exp_q.push_back(h);
      drive(1'b1, h, 1'b0, z);
      step();
      drive(1'b0, z, 1'b0, z);
      check("t1_valid_e1", hit_valid_R19H, 1'b0);
      step();
      check("t1_valid_e2", hit_valid_R19H, 1'b1);
      step();
      check("t1_valid_e3", hit_valid_R19H, 1'b0);
      check("t1_count", hit_count_RnnnnU, 32'd1);

      // Both lanes for four cycles: round-robin from lane 0 gives strict alternation.
      for (int i = 0; i < 4; i++) begin
         a[i] = mk(10 + i, -1 - i, i, i, 0, 16);
         b[i] = mk(100 + i, 5, -7 * (i + 1), 0, i, 32);
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(a[i]);
         exp_q.push_back(b[i]);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, a[i], 1'b1, b[i]);
         step();
      end
      drive(1'b0, z, 1'b0, z);
      drain("t2_drain");
      check("t2_count", hit_count_RnnnnU, 32'd9);

      // Stalled output: a lane-1 hit parks in the output register, lane 0 fills up.
      ready_R19H = 1'b0;
      x = mk(7, 7, 7, 1, 1, 1);
      exp_q.push_back(x);
      drive(1'b0, z, 1'b1, x);
      step();
      check("t3_halt_pre", halt_RnnnnL, 1'b1);
      for (int i = 0; i < 10; i++) begin
         h = mk(200 + i, i, -i, 9, 8, i);
         if (i < 8) exp_q.push_back(h);
         drive(1'b1, h, 1'b0, z);
         step();
         check("t3_halt", halt_RnnnnL, (i >= 3) ? 1'b0 : 1'b1);
         check("t3_ovf", overflow_RnnnnH, (i >= 8) ? 1'b1 : 1'b0);
         check("t3_valid", hit_valid_R19H, 1'b1);
      end
      drive(1'b0, z, 1'b0, z);
      ready_R19H = 1'b1;
      drain("t3_drain");
      check("t3_ovf_sticky", overflow_RnnnnH, 1'b1);
      check("t3_count", hit_count_RnnnnU, 32'd18);
      check("t3_halt_post", halt_RnnnnL, 1'b1);

      // Reset mid-drain: only the first of three hits escapes.
      for (int i = 0; i < 3; i++) begin
         h = mk(300 + i, 1, 1, 2, 2, 2);
         exp_q.push_back(h);
         drive(1'b1, h, 1'b0, z);
         step();
      end
      drive(1'b0, z, 1'b0, z);
      rst = 1'b0;
      #1;
      check("t4_pending", exp_q.size(), 2);
      check("t4_valid", hit_valid_R19H, 1'b0);
      check("t4_payload", {hit_R19S, color_R19U}, 144'd0);
      check("t4_halt", halt_RnnnnL, 1'b1);
      check("t4_ovf", overflow_RnnnnH, 1'b0);
      check("t4_count", hit_count_RnnnnU, 32'd0);
      exp_q.delete();
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t4_no_stale", hit_valid_R19H, 1'b0);
      end
      check("t4_count_post", hit_count_RnnnnU, 32'd0);

      // Full lane 0 then push and pop together: accepted without overflow.
      ready_R19H = 1'b0;
      for (int i = 0; i < 13; i++) begin
         h = mk(400 + i, -i, 3, i, 255, 0);
         exp_q.push_back(h);
         if (i == 9) ready_R19H = 1'b1;
         drive(1'b1, h, 1'b0, z);
         step();
         if (i >= 8) begin
            check("t6_ovf", overflow_RnnnnH, 1'b0);
            check("t6_halt", halt_RnnnnL, 1'b0);
         end
      end
      drive(1'b0, z, 1'b0, z);
      drain("t6_drain");
      check("t6_count", hit_count_RnnnnU, 32'd13);
      check("t6_ovf_end", overflow_RnnnnH, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
